sdp_ram_be_init: RTL and testbench

SDP_RAM_BE_INIT -- requirements
Module: sdp_ram_be_init

---
 rtl/sdp_ram_pkg.sv | 16 +
 rtl/ram_clear_ctrl.sv | 66 ++++++
 rtl/sdp_ram_be_init.sv | 129 ++++++++++++
 tb/tb_sdp_ram_be_init.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_ram_pkg.sv
// Shared types and constants for the byte-enable simple-dual-port RAM with clear engine.
package sdp_ram_pkg;

    localparam int unsigned BYTE_W = 8;

    // Read-during-write selection values for RDW_MODE
    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    typedef enum logic [1:0] {
        RST   = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } clr_state_e;

endpackage : sdp_ram_pkg

// File: rtl/ram_clear_ctrl.sv
// Clear engine: after reset, sweeps every address once with a zero write while busy is high.
module ram_clear_ctrl
    import sdp_ram_pkg::*;
#(
    parameter  int unsigned DEPTH          = 256,
    parameter  int unsigned CLEAR_ON_RESET = 1,
    localparam int unsigned AW             = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic          CLR_EN    = (CLEAR_ON_RESET != 0);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          busy_q, busy_d;
    logic          we_q, we_d;

    // Next state; busy and write strobe are decoded from the next state so they come straight off flops
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            RST: begin
                addr_d  = '0;
                state_d = CLR_EN ? CLEAR : READY;
            end
            CLEAR: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = READY;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            READY:   state_d = READY;
            default: state_d = RST;
        endcase
        busy_d = CLR_EN && (state_d != READY);
        we_d   = (state_d == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST;
            addr_q  <= '0;
            busy_q  <= CLR_EN;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
        end
    end

    assign busy     = busy_q;
    assign clr_we   = we_q;
    assign clr_addr = addr_q;

endmodule : ram_clear_ctrl

// File: rtl/sdp_ram_be_init.sv
// Simple-dual-port RAM with per-byte write enables, 1- or 2-cycle read pipeline and post-reset clear.
module sdp_ram_be_init
    import sdp_ram_pkg::*;
#(
    parameter  int unsigned WIDTH          = 32,
    parameter  int unsigned DEPTH          = 256,
    parameter  int unsigned RD_LATENCY     = 1,
    parameter  int unsigned RDW_MODE       = RDW_OLD,
    parameter  int unsigned CLEAR_ON_RESET = 1,
    localparam int unsigned AW             = $clog2(DEPTH),
    localparam int unsigned BW             = WIDTH / BYTE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [BW-1:0]    wr_be,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             init_busy
);

    localparam int unsigned AWX     = AW + 1;
    localparam logic [AW:0] DEPTH_X = AWX'(DEPTH);

    logic          busy;
    logic          clr_we;
    logic [AW-1:0] clr_addr;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_ok_c;
    logic             rd_ok_c;
    logic [WIDTH-1:0] rd_word_c;

    logic             p1_valid_q, p1_valid_d;
    logic [WIDTH-1:0] p1_data_q, p1_data_d;

    ram_clear_ctrl #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign init_busy = busy;

    // Request qualification and read-word selection, including optional write-through merge
    always_comb begin
        wr_ok_c   = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_X);
        rd_ok_c   = rd_en && !busy;
        rd_word_c = '0;
        if ({1'b0, rd_addr} < DEPTH_X) begin
            rd_word_c = mem[rd_addr];
            if ((RDW_MODE == RDW_NEW) && wr_ok_c && (wr_addr == rd_addr)) begin
                for (int k = 0; k < BW; k++) begin
                    if (wr_be[k]) begin
                        rd_word_c[BYTE_W*k +: BYTE_W] = wr_data[BYTE_W*k +: BYTE_W];
                    end
                end
            end
        end
    end

    // Memory array carries no reset; only the clear engine zeroes it
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok_c) begin
            for (int k = 0; k < BW; k++) begin
                if (wr_be[k]) begin
                    mem[wr_addr][BYTE_W*k +: BYTE_W] <= wr_data[BYTE_W*k +: BYTE_W];
                end
            end
        end
    end

    always_comb begin
        p1_valid_d = rd_ok_c;
        p1_data_d  = rd_ok_c ? rd_word_c : p1_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid_q <= 1'b0;
            p1_data_q  <= '0;
        end else begin
            p1_valid_q <= p1_valid_d;
            p1_data_q  <= p1_data_d;
        end
    end

    generate
        if (RD_LATENCY >= 2) begin : g_lat2
            logic             p2_valid_q, p2_valid_d;
            logic [WIDTH-1:0] p2_data_q, p2_data_d;

            // Output stage only loads on a completing read so rd_data holds between reads
            always_comb begin
                p2_valid_d = p1_valid_q;
                p2_data_d  = p1_valid_q ? p1_data_q : p2_data_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    p2_valid_q <= 1'b0;
                    p2_data_q  <= '0;
                end else begin
                    p2_valid_q <= p2_valid_d;
                    p2_data_q  <= p2_data_d;
                end
            end

            assign rd_valid = p2_valid_q;
            assign rd_data  = p2_data_q;
        end else begin : g_lat1
            assign rd_valid = p1_valid_q;
            assign rd_data  = p1_data_q;
        end
    endgenerate

endmodule : sdp_ram_be_init

// File: tb/tb_sdp_ram_be_init.sv
// Bench: two RAM instances (depth 16 / latency 1 / old-data and depth 12 / latency 2 / new-data)
// share one stimulus stream and are checked against an array-and-queue reference model.
module tb_sdp_ram_be_init;
    import sdp_ram_pkg::*;

    localparam int DA = 16;
    localparam int DB = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic        busy_a, busy_b;

    always #5 clk = ~clk;

    sdp_ram_be_init #(
        .WIDTH(32), .DEPTH(DA), .RD_LATENCY(1), .RDW_MODE(RDW_OLD), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .init_busy(busy_a)
    );

    sdp_ram_be_init #(
        .WIDTH(32), .DEPTH(DB), .RD_LATENCY(2), .RDW_MODE(RDW_NEW), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .init_busy(busy_b)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct { int due; logic [31:0] d; } rd_t;

    logic [31:0] ma [DA];
    logic [31:0] mb [DB];
    rd_t         qa [$];
    rd_t         qb [$];
    int          cyc = 0;
    int          rel = 0;
    bit          seen_rst = 1'b0;
    bit          mbusy_a = 1'b1;
    bit          mbusy_b = 1'b1;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;

    // Model update on each edge: a memory image per instance plus a queue of reads due on a given cycle
    always @(posedge clk) begin : model
        bit          pa, pb;
        logic [31:0] va, vb;
        cyc++;
        pa = mbusy_a;
        pb = mbusy_b;
        if (rst) begin
            seen_rst = 1'b1;
            rel      = 0;
            qa.delete();
            qb.delete();
            last_a   = '0;
            last_b   = '0;
            mbusy_a  = 1'b1;
            mbusy_b  = 1'b1;
        end else begin
            if (!pa && rd_en) begin
                va = ma[rd_addr];
                qa.push_back('{cyc, va});
            end
            if (!pa && wr_en)
                for (int k = 0; k < 4; k++)
                    if (wr_be[k]) ma[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
            if (!pb && wr_en && int'(wr_addr) < DB)
                for (int k = 0; k < 4; k++)
                    if (wr_be[k]) mb[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
            if (!pb && rd_en) begin
                vb = (int'(rd_addr) < DB) ? mb[rd_addr] : 32'h0;
                qb.push_back('{cyc + 1, vb});
            end
            rel++;
            mbusy_a = (rel <= DA);
            mbusy_b = (rel <= DB);
        end
        if (mbusy_a) foreach (ma[i]) ma[i] = '0;
        if (mbusy_b) foreach (mb[i]) mb[i] = '0;
    end

    // Per-cycle comparison on the falling edge
    always @(negedge clk) begin : monitor
        logic        ev;
        logic [31:0] ed;
        if (seen_rst) begin
            ev = 1'b0;
            ed = last_a;
            if (qa.size() > 0 && qa[0].due == cyc) begin
                ev = 1'b1; ed = qa[0].d; last_a = ed; void'(qa.pop_front());
            end
            chk("a_valid", 32'(rd_valid_a), 32'(ev));
            chk("a_data", rd_data_a, ed);
            chk("a_busy", 32'(busy_a), 32'(mbusy_a));
            ev = 1'b0;
            ed = last_b;
            if (qb.size() > 0 && qb[0].due == cyc) begin
                ev = 1'b1; ed = qb[0].d; last_b = ed; void'(qb.pop_front());
            end
            chk("b_valid", 32'(rd_valid_b), 32'(ev));
            chk("b_data", rd_data_b, ed);
            chk("b_busy", 32'(busy_b), 32'(mbusy_b));
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          we;
        logic [3:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          re;
        logic [3:0]  ra;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; wr_be = '0; wr_data = '0; rd_addr = '0;
    endtask

    task automatic count_busy(input bit rand_rd, output int na, output int nb, output int nbad);
        na = 0; nb = 0; nbad = 0;
        for (int i = 0; i < 40; i++) begin
            if (rand_rd) begin
                rd_en   = 1'($urandom_range(0, 1));
                rd_addr = 4'($urandom_range(0, 15));
            end
            step();
            na += int'(busy_a);
            nb += int'(busy_b);
            if (busy_a && rd_valid_a) nbad++;
            if (busy_b && rd_valid_b) nbad++;
        end
        idle();
    endtask

    initial begin
        int na, nb, nbad;

        vecs[0]  = '{1, 4'd3,  4'b1111, 32'hAABBCCDD, 0, 4'd0,  32'h0,        32'h0};
        vecs[1]  = '{1, 4'd3,  4'b0101, 32'h11223344, 0, 4'd0,  32'h0,        32'h0};
        vecs[2]  = '{0, 4'd0,  4'b0000, 32'h0,        1, 4'd3,  32'hAA22CC44, 32'hAA22CC44};
        vecs[3]  = '{1, 4'd5,  4'b1111, 32'h00000001, 0, 4'd0,  32'h0,        32'h0};
        vecs[4]  = '{1, 4'd5,  4'b1111, 32'h00000002, 1, 4'd5,  32'h00000001, 32'h00000002};
        vecs[5]  = '{0, 4'd0,  4'b0000, 32'h0,        1, 4'd5,  32'h00000002, 32'h00000002};
        vecs[6]  = '{1, 4'd13, 4'b1111, 32'hDEADBEEF, 0, 4'd0,  32'h0,        32'h0};
        vecs[7]  = '{0, 4'd0,  4'b0000, 32'h0,        1, 4'd13, 32'hDEADBEEF, 32'h0};
        vecs[8]  = '{1, 4'd7,  4'b0000, 32'hFFFFFFFF, 0, 4'd0,  32'h0,        32'h0};
        vecs[9]  = '{0, 4'd0,  4'b0000, 32'h0,        1, 4'd7,  32'h0,        32'h0};
        vecs[10] = '{1, 4'd6,  4'b1000, 32'h12345678, 1, 4'd6,  32'h0,        32'h12000000};
        vecs[11] = '{0, 4'd0,  4'b0000, 32'h0,        1, 4'd6,  32'h12000000, 32'h12000000};

        rst = 1'b1;
        idle();
        repeat (3) step();
        chk("rst_busy_a", 32'(busy_a), 32'd1);
        chk("rst_data_b", rd_data_b, 32'h0);

        // Clear after reset: busy for exactly DEPTH cycles, then everything reads zero
        rst = 1'b0;
        count_busy(1'b0, na, nb, nbad);
        chk("clear_len_a", 32'(na), 32'd16);
        chk("clear_len_b", 32'(nb), 32'd12);
        for (int a = 0; a < 16; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            step();
            chk("clear_zero_a", rd_data_a, 32'h0);
        end
        idle();
        repeat (3) step();

        // Back-to-back reads through the two-stage pipeline
        for (int a = 0; a < 4; a++) begin
            wr_en = 1'b1; wr_addr = 4'(a); wr_be = 4'hF; wr_data = 32'h100 + 32'(a);
            step();
        end
        idle();
        for (int i = 0; i < 6; i++) begin
            rd_en   = (i < 4);
            rd_addr = 4'(i);
            step();
            chk("lat2_valid", 32'(rd_valid_b), 32'((i >= 1) && (i <= 4)));
            if (i >= 1 && i <= 4) chk("lat2_data", rd_data_b, 32'h100 + 32'(i - 1));
        end
        idle();
        step();

        for (int i = 0; i < 12; i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_be = vecs[i].be; wr_data = vecs[i].wd;
            rd_en = vecs[i].re; rd_addr = vecs[i].ra;
            step();
            idle();
            if (vecs[i].re) begin
                chk("vec_a_valid", 32'(rd_valid_a), 32'd1);
                chk("vec_a_data", rd_data_a, vecs[i].ea);
            end
            step();
            if (vecs[i].re) begin
                chk("vec_b_valid", 32'(rd_valid_b), 32'd1);
                chk("vec_b_data", rd_data_b, vecs[i].eb);
            end
            step();
        end

        // Out-of-range write must not disturb the in-range words
        for (int a = 0; a < 12; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            step();
        end
        idle();
        repeat (3) step();

        // Reset while the clear is part way through restarts the full sweep
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        count_busy(1'b1, na, nb, nbad);
        chk("restart_len_a", 32'(na), 32'd16);
        chk("restart_len_b", 32'(nb), 32'd12);
        chk("valid_in_busy", 32'(nbad), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom_range(0, 15));
            wr_be   = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            step();
        end
        idle();
        repeat (3) step();

        // Reset with a read in flight in the two-stage pipeline
        rd_en = 1'b1; rd_addr = 4'd1;
        step();
        rd_en = 1'b0; rst = 1'b1;
        step();
        chk("flush_valid_b", 32'(rd_valid_b), 32'd0);
        chk("flush_data_b", rd_data_b, 32'h0);
        step();
        rst = 1'b0;
        repeat (20) step();
        chk("post_flush_busy_a", 32'(busy_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sdp_ram_be_init
